// File: rtl/actuated_phase_controller.sv
// Fully actuated signal controller for N_PHASES mutually conflicting approach phases.
// One phase is green at a time. Calls are served round-robin and phases without a call
// are skipped. With no demand the controller rests in green on REST_PHASE.
//
// Ports
//   clk          : clock
//   reset_n      : asynchronous active-low reset
//   car_detect   : per-phase vehicle detector (level)
//   ped_button   : per-phase pedestrian push button (level)
//   light        : per-phase vehicle head {R,Y,G}, phase i at [3i+2:3i]
//   ped_light    : per-phase pedestrian head {R,Y,G}: G = walk, Y = flashing don't walk
//   active_phase : phase currently timing
//   call_pending : car or pedestrian call latched per phase
//   maxout       : high in the cycle a green ends on the maximum timer
module actuated_phase_controller #(
    parameter int unsigned N_PHASES   = 4,
    parameter int unsigned MIN_GREEN  = 10,
    parameter int unsigned MAX_GREEN  = 40,
    parameter int unsigned GAP        = 5,
    parameter int unsigned YELLOW     = 4,
    parameter int unsigned ALL_RED    = 2,
    parameter int unsigned WALK       = 7,
    parameter int unsigned PED_CLEAR  = 6,
    parameter int unsigned REST_PHASE = 0
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [N_PHASES-1:0]           car_detect,
    input  logic [N_PHASES-1:0]           ped_button,
    output logic [3*N_PHASES-1:0]         light,
    output logic [3*N_PHASES-1:0]         ped_light,
    output logic [$clog2(N_PHASES)-1:0]   active_phase,
    output logic [N_PHASES-1:0]           call_pending,
    output logic                          maxout
);

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned PW        = $clog2(N_PHASES);
    localparam int unsigned PED_TOTAL = WALK + PED_CLEAR;
    localparam int unsigned PED_MIN   = max_u(MIN_GREEN, PED_TOTAL);
    localparam int unsigned LONGEST   = max_u(max_u(max_u(MAX_GREEN, PED_MIN), max_u(YELLOW,
                                              ALL_RED)), GAP);
    localparam int unsigned TW        = $clog2(LONGEST) + 1;
    localparam int unsigned GW        = $clog2(GAP) + 1;

    localparam logic [TW-1:0] T_SAT     = TW'(MAX_GREEN);
    localparam logic [TW-1:0] T_MAXOUT  = TW'(MAX_GREEN - 1);
    localparam logic [TW-1:0] T_MIN     = TW'(MIN_GREEN - 1);
    localparam logic [TW-1:0] T_PED_MIN = TW'(PED_MIN - 1);
    localparam logic [TW-1:0] T_YEL_END = TW'(YELLOW - 1);
    localparam logic [TW-1:0] T_AR_END  = TW'(ALL_RED - 1);
    localparam logic [TW-1:0] T_WALK    = TW'(WALK);
    localparam logic [TW-1:0] T_PED_END = TW'(PED_TOTAL);
    localparam logic [GW-1:0] GAP_LOAD  = GW'(GAP);

    localparam logic [2:0] HEAD_RED    = 3'b100;
    localparam logic [2:0] HEAD_YELLOW = 3'b010;
    localparam logic [2:0] HEAD_GREEN  = 3'b001;

    typedef enum logic [1:0] {StAllRed, StGreen, StYellow} state_e;

    state_e                 state_q, state_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic [GW-1:0]          gap_q, gap_d;
    logic [PW-1:0]          active_q, active_d;
    logic                   ped_served_q, ped_served_d;
    logic [N_PHASES-1:0]    car_call_q, car_call_d;
    logic [N_PHASES-1:0]    ped_call_q, ped_call_d;
    logic [3*N_PHASES-1:0]  light_q, light_d;
    logic [3*N_PHASES-1:0]  ped_light_q, ped_light_d;

    logic [N_PHASES-1:0]    pending;
    logic [N_PHASES-1:0]    active_oh;
    logic [N_PHASES-1:0]    green_mask;
    logic [N_PHASES-1:0]    walk_mask;
    logic [PW-1:0]          sel_phase;
    logic [PW-1:0]          scan_idx;
    logic                   conflict;
    logic                   min_met;
    logic                   walk_now;

    assign pending = car_call_q | ped_call_q;

    always_comb begin
        active_oh           = '0;
        active_oh[active_q] = 1'b1;
    end

    assign walk_now   = (state_q == StGreen) && ped_served_q && (timer_q < T_WALK);
    assign green_mask = (state_q == StGreen) ? active_oh : '0;
    assign walk_mask  = walk_now ? active_oh : '0;

    // Only a ped call on the active phase can be set during its green, and only once the
    // walk is over (or when no walk was given), so it always counts as fresh demand.
    assign conflict = (|(pending & ~active_oh)) | ped_call_q[active_q];
    assign min_met  = timer_q >= (ped_served_q ? T_PED_MIN : T_MIN);

    // Scan downward so the closest phase after active_q wins; active_q itself is last.
    always_comb begin
        sel_phase = PW'(REST_PHASE);
        scan_idx  = '0;
        for (int k = int'(N_PHASES); k >= 1; k--) begin
            scan_idx = PW'((int'(active_q) + k) % int'(N_PHASES));
            if (pending[scan_idx]) begin
                sel_phase = scan_idx;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        timer_d      = (timer_q == T_SAT) ? timer_q : timer_q + TW'(1);
        gap_d        = gap_q;
        active_d     = active_q;
        ped_served_d = ped_served_q;
        car_call_d   = car_call_q | (car_detect & ~green_mask);
        ped_call_d   = ped_call_q | (ped_button & ~walk_mask);
        maxout       = 1'b0;

        unique case (state_q)
            StAllRed: begin
                if (timer_q == T_AR_END) begin
                    state_d               = StGreen;
                    active_d              = sel_phase;
                    gap_d                 = GAP_LOAD;
                    ped_served_d          = ped_call_q[sel_phase];
                    // Clearing the served calls overrides any set in this same cycle.
                    car_call_d[sel_phase] = 1'b0;
                    ped_call_d[sel_phase] = 1'b0;
                end
            end
            StGreen: begin
                if (car_detect[active_q]) begin
                    gap_d = GAP_LOAD;
                end else if (gap_q != '0) begin
                    gap_d = gap_q - GW'(1);
                end
                if (min_met && conflict && ((gap_q == '0) || (timer_q >= T_MAXOUT))) begin
                    state_d = StYellow;
                    maxout  = (gap_q != '0);
                end
            end
            StYellow: begin
                if (timer_q == T_YEL_END) begin
                    state_d = StAllRed;
                end
            end
            default: begin
                state_d = StAllRed;
            end
        endcase

        if (state_d != state_q) begin
            timer_d = '0;
        end
    end

    // Heads are computed from next state so the registered outputs line up with the state.
    always_comb begin
        light_d     = {N_PHASES{HEAD_RED}};
        ped_light_d = {N_PHASES{HEAD_RED}};
        for (int i = 0; i < int'(N_PHASES); i++) begin
            if (active_d == PW'(i)) begin
                if (state_d == StGreen) begin
                    light_d[3*i +: 3] = HEAD_GREEN;
                    if (ped_served_d) begin
                        if (timer_d < T_WALK) begin
                            ped_light_d[3*i +: 3] = HEAD_GREEN;
                        end else if (timer_d < T_PED_END) begin
                            ped_light_d[3*i +: 3] = HEAD_YELLOW;
                        end
                    end
                end else if (state_d == StYellow) begin
                    light_d[3*i +: 3] = HEAD_YELLOW;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StAllRed;
            timer_q      <= '0;
            gap_q        <= '0;
            active_q     <= PW'(REST_PHASE);
            ped_served_q <= 1'b0;
            car_call_q   <= '0;
            ped_call_q   <= '0;
            light_q      <= {N_PHASES{HEAD_RED}};
            ped_light_q  <= {N_PHASES{HEAD_RED}};
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            gap_q        <= gap_d;
            active_q     <= active_d;
            ped_served_q <= ped_served_d;
            car_call_q   <= car_call_d;
            ped_call_q   <= ped_call_d;
            light_q      <= light_d;
            ped_light_q  <= ped_light_d;
        end
    end

    assign light        = light_q;
    assign ped_light    = ped_light_q;
    assign active_phase = active_q;
    assign call_pending = pending;

endmodule

// File: tb/tb_actuated_phase_controller.sv
// Directed bench for actuated_phase_controller with default parameters (4 phases).
module tb_actuated_phase_controller;

    localparam logic [11:0] ALL_R = 12'h924;
    localparam logic [11:0] P0_G  = 12'h921;
    localparam logic [11:0] P0_Y  = 12'h922;
    localparam logic [11:0] P1_G  = 12'h90C;
    localparam logic [11:0] P1_Y  = 12'h914;
    localparam logic [11:0] P2_G  = 12'h864;
    localparam logic [11:0] P3_G  = 12'h324;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  car_detect;
    logic [3:0]  ped_button;
    logic [11:0] light;
    logic [11:0] ped_light;
    logic [1:0]  active_phase;
    logic [3:0]  call_pending;
    logic        maxout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    actuated_phase_controller #(
        .N_PHASES  (4),
        .MIN_GREEN (10),
        .MAX_GREEN (40),
        .GAP       (5),
        .YELLOW    (4),
        .ALL_RED   (2),
        .WALK      (7),
        .PED_CLEAR (6),
        .REST_PHASE(0)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .car_detect  (car_detect),
        .ped_button  (ped_button),
        .light       (light),
        .ped_light   (ped_light),
        .active_phase(active_phase),
        .call_pending(call_pending),
        .maxout      (maxout)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_light(input logic [11:0] want, input int bound, output bit found);
        found = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (light === want) begin
                found = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        car_detect = '0;
        ped_button = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (light !== ALL_R) begin errors++;
            $display("FAIL reset_light got %h want %h", light, ALL_R); end
        checks++; if (ped_light !== ALL_R) begin errors++;
            $display("FAIL reset_ped got %h want %h", ped_light, ALL_R); end
        checks++; if (call_pending !== 4'b0) begin errors++;
            $display("FAIL reset_calls got %b want 0000", call_pending); end
        checks++; if (active_phase !== 2'd0) begin errors++;
            $display("FAIL reset_active got %0d want 0", active_phase); end
        checks++; if (maxout !== 1'b0) begin errors++;
            $display("FAIL reset_maxout got %b want 0", maxout); end
        reset_n = 1'b1;
        tick();
        checks++; if (light !== ALL_R) begin errors++;
            $display("FAIL allred_2nd got %h want %h", light, ALL_R); end
        tick();
        checks++; if (light !== P0_G) begin errors++;
            $display("FAIL rest_entry got %h want %h", light, P0_G); end
    endtask

    task automatic test_rest();
        for (int i = 0; i < 220; i++) begin
            checks++; if (light !== P0_G) begin errors++;
                $display("FAIL rest_light cyc %0d got %h want %h", i, light, P0_G); end
            checks++; if (maxout !== 1'b0) begin errors++;
                $display("FAIL rest_maxout cyc %0d got %b want 0", i, maxout); end
            checks++; if (ped_light !== ALL_R) begin errors++;
                $display("FAIL rest_ped cyc %0d got %h want %h", i, ped_light, ALL_R); end
            tick();
        end
    endtask

    task automatic test_skip();
        car_detect = 4'b0100;
        tick();
        car_detect = '0;
        checks++; if (call_pending !== 4'b0100) begin errors++;
            $display("FAIL skip_latch got %b want 0100", call_pending); end
        checks++; if (light !== P0_G || maxout !== 1'b0) begin errors++;
            $display("FAIL skip_term got %h/%b want %h/0", light, maxout, P0_G); end
        tick();
        for (int y = 0; y < 4; y++) begin
            checks++; if (light !== P0_Y) begin errors++;
                $display("FAIL skip_yellow %0d got %h want %h", y, light, P0_Y); end
            tick();
        end
        for (int a = 0; a < 2; a++) begin
            checks++; if (light !== ALL_R) begin errors++;
                $display("FAIL skip_allred %0d got %h want %h", a, light, ALL_R); end
            tick();
        end
        checks++; if (light !== P2_G || active_phase !== 2'd2) begin errors++;
            $display("FAIL skip_green got %h/%0d want %h/2", light, active_phase, P2_G); end
        checks++; if (call_pending !== 4'b0000) begin errors++;
            $display("FAIL skip_clear got %b want 0000", call_pending); end
    endtask

    task automatic test_maxout();
        bit   found;
        logic exp_mo;
        car_detect = 4'b0010;
        tick();
        car_detect = '0;
        wait_light(P1_G, 60, found);
        checks++; if (!found) begin errors++;
            $display("FAIL maxout_reach got %h want %h", light, P1_G); end
        for (int t = 0; t < 40; t++) begin
            exp_mo = (t == 39);
            checks++; if (light !== P1_G) begin errors++;
                $display("FAIL maxout_green t%0d got %h want %h", t, light, P1_G); end
            checks++; if (maxout !== exp_mo) begin errors++;
                $display("FAIL maxout_pulse t%0d got %b want %b", t, maxout, exp_mo); end
            car_detect = {(t == 0), 1'b0, (t % 3 == 0), 1'b0};
            tick();
        end
        car_detect = '0;
        checks++; if (light !== P1_Y || maxout !== 1'b0) begin errors++;
            $display("FAIL maxout_yellow got %h/%b want %h/0", light, maxout, P1_Y); end
        car_detect = 4'b0010;
        tick();
        car_detect = '0;
    endtask

    task automatic test_gapout();
        bit found;
        wait_light(P1_G, 80, found);
        checks++; if (!found) begin errors++;
            $display("FAIL gap_reach got %h want %h", light, P1_G); end
        for (int t = 0; t < 18; t++) begin
            checks++; if (light !== P1_G) begin errors++;
                $display("FAIL gap_green t%0d got %h want %h", t, light, P1_G); end
            checks++; if (maxout !== 1'b0) begin errors++;
                $display("FAIL gap_maxout t%0d got %b want 0", t, maxout); end
            car_detect = {(t == 0), 1'b0, (t % 3 == 2 && t <= 11), 1'b0};
            tick();
        end
        car_detect = '0;
        checks++; if (light !== P1_Y) begin errors++;
            $display("FAIL gap_yellow got %h want %h", light, P1_Y); end
        car_detect = 4'b0001;
        tick();
        car_detect = '0;
    endtask

    task automatic test_ped();
        bit          found;
        logic [11:0] exp_ped;
        wait_light(P0_G, 80, found);
        checks++; if (!found) begin errors++;
            $display("FAIL ped_reach_p0 got %h want %h", light, P0_G); end
        repeat (15) tick();
        checks++; if (call_pending !== 4'b0000) begin errors++;
            $display("FAIL ped_idle got %b want 0000", call_pending); end
        ped_button = 4'b0010;
        tick();
        ped_button = '0;
        checks++; if (call_pending !== 4'b0010) begin errors++;
            $display("FAIL ped_latch got %b want 0010", call_pending); end
        tick();
        checks++; if (light !== P0_Y) begin errors++;
            $display("FAIL ped_p0_yellow got %h want %h", light, P0_Y); end
        wait_light(P1_G, 20, found);
        checks++; if (!found) begin errors++;
            $display("FAIL ped_reach_p1 got %h want %h", light, P1_G); end
        for (int t = 0; t < 27; t++) begin
            exp_ped = (t < 7) ? P1_G : ((t < 13) ? P1_Y : ALL_R);
            checks++; if (ped_light !== exp_ped) begin errors++;
                $display("FAIL ped_head t%0d got %h want %h", t, ped_light, exp_ped); end
            checks++; if (light !== P1_G) begin errors++;
                $display("FAIL ped_green t%0d got %h want %h", t, light, P1_G); end
            checks++; if (call_pending !== 4'b0000) begin errors++;
                $display("FAIL ped_nolatch t%0d got %b want 0000", t, call_pending); end
            ped_button = (t == 2 || t == 26) ? 4'b0010 : 4'b0000;
            tick();
        end
        ped_button = '0;
        checks++; if (call_pending !== 4'b0010 || light !== P1_G) begin errors++;
            $display("FAIL ped_relatch got %b/%h want 0010/%h", call_pending, light, P1_G); end
        tick();
        checks++; if (light !== P1_Y || ped_light !== ALL_R) begin errors++;
            $display("FAIL ped_reterm got %h/%h want %h/%h", light, ped_light, P1_Y, ALL_R); end
        car_detect = 4'b0100;
        tick();
        car_detect = '0;
    endtask

    task automatic test_order();
        bit found;
        bit seen;
        wait_light(P2_G, 80, found);
        checks++; if (!found) begin errors++;
            $display("FAIL order_reach got %h want %h", light, P2_G); end
        car_detect = 4'b1010;
        tick();
        car_detect = '0;
        checks++; if (call_pending !== 4'b1010) begin errors++;
            $display("FAIL order_calls got %b want 1010", call_pending); end
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            if (light === P0_G || light === P1_G || light === P3_G) seen = 1'b1;
            else tick();
        end
        checks++; if (light !== P3_G || active_phase !== 2'd3) begin errors++;
            $display("FAIL order_first got %h/%0d want %h/3", light, active_phase, P3_G); end
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            if (light === P0_G || light === P1_G) seen = 1'b1;
            else tick();
        end
        checks++; if (light !== P1_G || active_phase !== 2'd1) begin errors++;
            $display("FAIL order_second got %h/%0d want %h/1", light, active_phase, P1_G); end
    endtask

    task automatic test_reset_mid_yellow();
        bit found;
        car_detect = 4'b0001;
        tick();
        car_detect = '0;
        wait_light(P1_Y, 40, found);
        checks++; if (!found) begin errors++;
            $display("FAIL rst_reach got %h want %h", light, P1_Y); end
        car_detect = 4'b0100;
        tick();
        car_detect = '0;
        checks++; if (light !== P1_Y || call_pending !== 4'b0101) begin errors++;
            $display("FAIL rst_pre got %h/%b want %h/0101", light, call_pending, P1_Y); end
        #3;
        reset_n = 1'b0;
        #1;
        checks++; if (light !== ALL_R || ped_light !== ALL_R) begin errors++;
            $display("FAIL rst_heads got %h/%h want %h", light, ped_light, ALL_R); end
        checks++; if (call_pending !== 4'b0000 || active_phase !== 2'd0 || maxout !== 1'b0)
        begin errors++;
            $display("FAIL rst_state got %b/%0d/%b want 0000/0/0",
                     call_pending, active_phase, maxout); end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick();
        checks++; if (light !== ALL_R) begin errors++;
            $display("FAIL rst_allred got %h want %h", light, ALL_R); end
        tick();
        checks++; if (light !== P0_G) begin errors++;
            $display("FAIL rst_rest got %h want %h", light, P0_G); end
    endtask

    initial begin
        test_reset();
        test_rest();
        test_skip();
        test_maxout();
        test_gapout();
        test_ped();
        test_order();
        test_reset_mid_yellow();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

endmodule
